scoreboard: RTL and testbench



---
 rtl/ariane_pkg.sv | 50 +++++
 rtl/scoreboard_fwd_lookup.sv | 46 ++++
 rtl/scoreboard.sv | 166 ++++++++++++++++
 tb/tb_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard entry, exception record, functional-unit ids, cause codes.
// Sizing here fixes the trans_id width that issue, writeback and commit agree on.
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned NR_WB_PORTS   = 3;

    localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
    localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
    localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;
    localparam logic [63:0] BREAKPOINT            = 64'd3;
    localparam logic [63:0] LD_ADDR_MISALIGNED    = 64'd4;
    localparam logic [63:0] LD_ACCESS_FAULT       = 64'd5;
    localparam logic [63:0] ST_ADDR_MISALIGNED    = 64'd6;
    localparam logic [63:0] ST_ACCESS_FAULT       = 64'd7;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        LOAD      = 4'd1,
        STORE     = 4'd2,
        ALU       = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT      = 4'd5,
        CSR       = 4'd6
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        logic                     use_pc;
        exception                 ex;
        logic                     is_compressed;
    } scoreboard_entry;

endpackage

// File: rtl/scoreboard_fwd_lookup.sv
// Youngest-match operand search over the in-flight window, walking from wr_ptr-1 back to rd_ptr.
// Purely combinational; register x0 never hits.
module sb_fwd_lookup #(
    parameter int unsigned NR_ENTRIES = 4,
    parameter int unsigned PTR_W      = 2
) (
    input  logic [NR_ENTRIES-1:0]       i_occupied,
    input  logic [NR_ENTRIES-1:0][4:0]  i_rd,
    input  logic [NR_ENTRIES-1:0]       i_valid,
    input  logic [NR_ENTRIES-1:0][63:0] i_result,
    input  logic [PTR_W-1:0]            i_rd_ptr,
    input  logic [PTR_W-1:0]            i_wr_ptr,
    input  logic [4:0]                  i_rs,
    output logic                        o_hit,
    output logic                        o_valid,
    output logic [63:0]                 o_data
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    logic             w_stop;

    always_comb begin
        o_hit   = 1'b0;
        o_valid = 1'b0;
        o_data  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_stop  = 1'b0;
        // First match on the youngest-first walk wins; the walk ends once the head has been visited.
        for (int k = 0; k < int'(NR_ENTRIES); k++) begin
            w_idx = i_wr_ptr - PTR_W'(k + 1);
            if (!w_found && !w_stop && i_occupied[w_idx] &&
                (i_rd[w_idx] == i_rs) && (i_rs != 5'd0)) begin
                w_found = 1'b1;
                o_hit   = 1'b1;
                o_valid = i_valid[w_idx];
                o_data  = i_result[w_idx];
            end
            if (w_idx == i_rd_ptr) begin
                w_stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scoreboard.sv
// In-order scoreboard: allocates trans_ids at issue, collects FU writebacks, retires the head in order.
// Issue->commit latency 1 cycle; issue is refused while all entries are in flight (no same-cycle bypass).
module scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     flush_i,
    input  scoreboard_entry                          issue_instr_i,
    input  logic                                     issue_valid_i,
    output logic                                     issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                 issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]             wb_data_i,
    input  exception [NR_WB_PORTS-1:0]               wb_ex_i,
    input  logic [NR_WB_PORTS-1:0]                   wb_valid_i,
    input  logic [4:0]                               rs1_i,
    input  logic [4:0]                               rs2_i,
    output logic                                     rs1_hit_o,
    output logic                                     rs2_hit_o,
    output logic                                     rs1_valid_o,
    output logic                                     rs2_valid_o,
    output logic [63:0]                              rs1_o,
    output logic [63:0]                              rs2_o,
    output scoreboard_entry                          commit_instr_o,
    output logic                                     commit_valid_o,
    input  logic                                     commit_ack_i
);

    localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

    scoreboard_entry [NR_ENTRIES-1:0] r_mem;
    logic [NR_ENTRIES-1:0]            r_occupied;
    logic [TRANS_ID_BITS-1:0]         r_wr_ptr;
    logic [TRANS_ID_BITS-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]                 r_count;

    scoreboard_entry [NR_ENTRIES-1:0] w_mem_d;
    logic [NR_ENTRIES-1:0]            w_occ_d;
    logic [NR_ENTRIES-1:0]            w_wb_taken;
    scoreboard_entry                  w_head;
    logic                             w_issue_fire;
    logic                             w_commit_fire;

    logic [NR_ENTRIES-1:0][4:0]       w_rd;
    logic [NR_ENTRIES-1:0]            w_res_vld;
    logic [NR_ENTRIES-1:0][63:0]      w_res;

    assign w_head           = r_mem[r_rd_ptr];
    assign issue_ready_o    = (r_count != CNT_W'(NR_ENTRIES));
    assign issue_trans_id_o = r_wr_ptr;
    assign commit_valid_o   = r_occupied[r_rd_ptr] & w_head.valid;
    assign commit_instr_o   = w_head;

    // Flush suppresses every other state change in its cycle.
    assign w_issue_fire  = issue_valid_i & issue_ready_o & ~flush_i;
    assign w_commit_fire = commit_valid_o & commit_ack_i & ~flush_i;

    always_comb begin
        w_mem_d    = r_mem;
        w_occ_d    = r_occupied;
        w_wb_taken = '0;
        if (w_issue_fire) begin
            w_mem_d[r_wr_ptr]          = issue_instr_i;
            w_mem_d[r_wr_ptr].trans_id = r_wr_ptr;
            w_mem_d[r_wr_ptr].valid    = issue_instr_i.valid | issue_instr_i.ex.valid;
            w_occ_d[r_wr_ptr]          = 1'b1;
        end
        // Ports scanned low to high; an entry already claimed this cycle keeps the lower port's data.
        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            if (!flush_i && wb_valid_i[p] && r_occupied[wb_trans_id_i[p]] &&
                !w_wb_taken[wb_trans_id_i[p]]) begin
                w_wb_taken[wb_trans_id_i[p]]     = 1'b1;
                w_mem_d[wb_trans_id_i[p]].result = wb_data_i[p];
                w_mem_d[wb_trans_id_i[p]].valid  = 1'b1;
                if (wb_ex_i[p].valid) begin
                    w_mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
                end
            end
        end
        if (w_commit_fire) begin
            w_occ_d[r_rd_ptr] = 1'b0;
        end
        if (flush_i) begin
            w_occ_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem      <= '0;
            r_occupied <= '0;
        end else begin
            r_mem      <= w_mem_d;
            r_occupied <= w_occ_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue_fire) begin
                r_wr_ptr <= r_wr_ptr + TRANS_ID_BITS'(1);
            end
            if (w_commit_fire) begin
                r_rd_ptr <= r_rd_ptr + TRANS_ID_BITS'(1);
            end
            case ({w_issue_fire, w_commit_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NR_ENTRIES); k++) begin
            w_rd[k]      = r_mem[k].rd;
            w_res_vld[k] = r_mem[k].valid;
            w_res[k]     = r_mem[k].result;
        end
    end

    sb_fwd_lookup #(
        .NR_ENTRIES (NR_ENTRIES),
        .PTR_W      (TRANS_ID_BITS)
    ) u_fwd_rs1 (
        .i_occupied (r_occupied),
        .i_rd       (w_rd),
        .i_valid    (w_res_vld),
        .i_result   (w_res),
        .i_rd_ptr   (r_rd_ptr),
        .i_wr_ptr   (r_wr_ptr),
        .i_rs       (rs1_i),
        .o_hit      (rs1_hit_o),
        .o_valid    (rs1_valid_o),
        .o_data     (rs1_o)
    );

    sb_fwd_lookup #(
        .NR_ENTRIES (NR_ENTRIES),
        .PTR_W      (TRANS_ID_BITS)
    ) u_fwd_rs2 (
        .i_occupied (r_occupied),
        .i_rd       (w_rd),
        .i_valid    (w_res_vld),
        .i_result   (w_res),
        .i_rd_ptr   (r_rd_ptr),
        .i_wr_ptr   (r_wr_ptr),
        .i_rs       (rs2_i),
        .o_hit      (rs2_hit_o),
        .o_valid    (rs2_valid_o),
        .o_data     (rs2_o)
    );

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: fill/drain ordering, full-with-commit, forwarding, exceptions, flush, reset.
module tb_scoreboard;
    import ariane_pkg::*;

    localparam int unsigned NWB = NR_WB_PORTS;
    localparam int unsigned TB  = TRANS_ID_BITS;

    logic                           clk_i;
    logic                           rst_ni;
    logic                           flush_i;
    scoreboard_entry                issue_instr_i;
    logic                           issue_valid_i;
    logic                           issue_ready_o;
    logic [TB-1:0]                  issue_trans_id_o;
    logic [NWB-1:0][TB-1:0]         wb_trans_id_i;
    logic [NWB-1:0][63:0]           wb_data_i;
    exception [NWB-1:0]             wb_ex_i;
    logic [NWB-1:0]                 wb_valid_i;
    logic [4:0]                     rs1_i;
    logic [4:0]                     rs2_i;
    logic                           rs1_hit_o;
    logic                           rs2_hit_o;
    logic                           rs1_valid_o;
    logic                           rs2_valid_o;
    logic [63:0]                    rs1_o;
    logic [63:0]                    rs2_o;
    scoreboard_entry                commit_instr_o;
    logic                           commit_valid_o;
    logic                           commit_ack_i;

    int n_cmp = 0;
    int n_mis = 0;

    scoreboard dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .issue_instr_i    (issue_instr_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_trans_id_o (issue_trans_id_o),
        .wb_trans_id_i    (wb_trans_id_i),
        .wb_data_i        (wb_data_i),
        .wb_ex_i          (wb_ex_i),
        .wb_valid_i       (wb_valid_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .rs1_hit_o        (rs1_hit_o),
        .rs2_hit_o        (rs2_hit_o),
        .rs1_valid_o      (rs1_valid_o),
        .rs2_valid_o      (rs2_valid_o),
        .rs1_o            (rs1_o),
        .rs2_o            (rs2_o),
        .commit_instr_o   (commit_instr_o),
        .commit_valid_o   (commit_valid_o),
        .commit_ack_i     (commit_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic scoreboard_entry mk(input logic [4:0] rd, input logic vld,
                                           input logic exv, input logic [63:0] cause);
        scoreboard_entry e;
        e          = '0;
        e.pc       = 64'h1000 + 64'(rd);
        e.fu       = ALU;
        e.trans_id = '1;
        e.rd       = rd;
        e.valid    = vld;
        e.ex.valid = exv;
        e.ex.cause = cause;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input scoreboard_entry e);
        issue_instr_i = e;
        issue_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        #1;
    endtask

    task automatic do_wb(input int p, input logic [TB-1:0] id, input logic [63:0] d,
                         input logic exv, input logic [63:0] cause);
        wb_valid_i[p]     = 1'b1;
        wb_trans_id_i[p]  = id;
        wb_data_i[p]      = d;
        wb_ex_i[p].valid  = exv;
        wb_ex_i[p].cause  = cause;
        @(posedge clk_i);
        #1;
        wb_valid_i = '0;
        wb_ex_i    = '0;
        #1;
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        issue_instr_i = '0;
        issue_valid_i = 1'b0;
        wb_trans_id_i = '0;
        wb_data_i     = '0;
        wb_ex_i       = '0;
        wb_valid_i    = '0;
        rs1_i         = 5'd0;
        rs2_i         = 5'd0;
        commit_ack_i  = 1'b0;
        #3;
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_tid", 64'(issue_trans_id_o), 64'd0);
        chk("rst_cvalid", 64'(commit_valid_o), 64'd0);
        chk("rst_cinstr_nz", 64'(commit_instr_o != '0), 64'd0);
        chk("rst_rs1_hit", 64'(rs1_hit_o), 64'd0);
        chk("rst_rs2_o", rs2_o, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();

        // Fill with pending entries, then write back out of order while acking continuously.
        for (int i = 0; i < 4; i++) do_issue(mk(5'(i + 1), 1'b0, 1'b0, 64'd0));
        chk("fill_ready", 64'(issue_ready_o), 64'd0);
        chk("fill_tid_wrap", 64'(issue_trans_id_o), 64'd0);
        chk("fill_count", 64'(dut.r_count), 64'd4);
        commit_ack_i = 1'b1;
        do_wb(0, 2'd2, 64'h20, 1'b0, 64'd0);
        chk("wb2_cvalid", 64'(commit_valid_o), 64'd0);
        do_wb(0, 2'd0, 64'h10, 1'b0, 64'd0);
        chk("wb0_cvalid", 64'(commit_valid_o), 64'd1);
        chk("wb0_ctid", 64'(commit_instr_o.trans_id), 64'd0);
        chk("wb0_cres", commit_instr_o.result, 64'h10);
        do_wb(0, 2'd3, 64'h30, 1'b0, 64'd0);
        chk("c0_done_cvalid", 64'(commit_valid_o), 64'd0);
        chk("c0_done_count", 64'(dut.r_count), 64'd3);
        do_wb(0, 2'd1, 64'h40, 1'b0, 64'd0);
        chk("c1_ctid", 64'(commit_instr_o.trans_id), 64'd1);
        step();
        chk("c2_ctid", 64'(commit_instr_o.trans_id), 64'd2);
        chk("c2_cres", commit_instr_o.result, 64'h20);
        step();
        chk("c3_ctid", 64'(commit_instr_o.trans_id), 64'd3);
        chk("c3_rd", 64'(commit_instr_o.rd), 64'd4);
        step();
        chk("drain_cvalid", 64'(commit_valid_o), 64'd0);
        chk("drain_count", 64'(dut.r_count), 64'd0);
        commit_ack_i = 1'b0;

        // Full scoreboard with a same-cycle commit must still refuse the issue.
        for (int i = 0; i < 4; i++) do_issue(mk(5'd0, 1'b1, 1'b0, 64'd0));
        chk("full_cvalid", 64'(commit_valid_o), 64'd1);
        issue_instr_i = mk(5'd0, 1'b1, 1'b0, 64'd0);
        issue_valid_i = 1'b1;
        commit_ack_i  = 1'b1;
        #1;
        chk("full_ack_ready", 64'(issue_ready_o), 64'd0);
        step();
        issue_valid_i = 1'b0;
        commit_ack_i  = 1'b0;
        #1;
        chk("full_after_count", 64'(dut.r_count), 64'd3);
        chk("full_after_ready", 64'(issue_ready_o), 64'd1);
        chk("full_after_tid", 64'(issue_trans_id_o), 64'd0);
        chk("full_after_head", 64'(commit_instr_o.trans_id), 64'd1);
        commit_ack_i = 1'b1;
        step(); step(); step();
        commit_ack_i = 1'b0;
        chk("full_drain_count", 64'(dut.r_count), 64'd0);

        // Forwarding: ids 0 and 2 both target x5, id 1 targets x6.
        do_issue(mk(5'd5, 1'b0, 1'b0, 64'd0));
        do_issue(mk(5'd6, 1'b0, 1'b0, 64'd0));
        do_issue(mk(5'd5, 1'b0, 1'b0, 64'd0));
        do_wb(0, 2'd0, 64'hA, 1'b0, 64'd0);
        rs1_i = 5'd5;
        rs2_i = 5'd0;
        #1;
        chk("fwd_rs1_hit", 64'(rs1_hit_o), 64'd1);
        chk("fwd_rs1_valid", 64'(rs1_valid_o), 64'd0);
        chk("fwd_rs1_data", rs1_o, 64'd0);
        chk("fwd_rs2_x0_hit", 64'(rs2_hit_o), 64'd0);
        rs2_i = 5'd6;
        wb_valid_i[2]    = 1'b1;
        wb_trans_id_i[2] = 2'd1;
        wb_data_i[2]     = 64'hC;
        #1;
        chk("fwd_samecyc_valid", 64'(rs2_valid_o), 64'd0);
        chk("fwd_samecyc_hit", 64'(rs2_hit_o), 64'd1);
        step();
        wb_valid_i = '0;
        #1;
        chk("fwd_rs2_valid", 64'(rs2_valid_o), 64'd1);
        chk("fwd_rs2_data", rs2_o, 64'hC);
        do_wb(1, 2'd2, 64'hB, 1'b0, 64'd0);
        chk("fwd_young_data", rs1_o, 64'hB);
        chk("fwd_young_valid", 64'(rs1_valid_o), 64'd1);
        commit_ack_i = 1'b1;
        step(); step(); step();
        commit_ack_i = 1'b0;
        rs1_i = 5'd0;
        rs2_i = 5'd0;
        chk("fwd_drain_count", 64'(dut.r_count), 64'd0);

        // Exception at issue commits without writeback; FU exception overrides cause.
        do_issue(mk(5'd0, 1'b0, 1'b1, ILLEGAL_INSTR));
        chk("exi_cvalid", 64'(commit_valid_o), 64'd1);
        chk("exi_cause", commit_instr_o.ex.cause, 64'd2);
        chk("exi_tid", 64'(commit_instr_o.trans_id), 64'd3);
        commit_ack_i = 1'b1;
        step();
        commit_ack_i = 1'b0;
        #1;
        do_issue(mk(5'd0, 1'b0, 1'b0, 64'd0));
        chk("exw_pend_cvalid", 64'(commit_valid_o), 64'd0);
        do_wb(1, 2'd0, 64'h55, 1'b1, LD_ACCESS_FAULT);
        chk("exw_cvalid", 64'(commit_valid_o), 64'd1);
        chk("exw_cause", commit_instr_o.ex.cause, 64'd5);
        chk("exw_exvalid", 64'(commit_instr_o.ex.valid), 64'd1);
        commit_ack_i = 1'b1;
        step();
        commit_ack_i = 1'b0;
        #1;

        // Flush with three pending entries and a same-cycle issue.
        for (int i = 0; i < 3; i++) do_issue(mk(5'(i + 10), 1'b0, 1'b0, 64'd0));
        chk("pre_flush_count", 64'(dut.r_count), 64'd3);
        flush_i       = 1'b1;
        issue_instr_i = mk(5'd13, 1'b1, 1'b0, 64'd0);
        issue_valid_i = 1'b1;
        step();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        #1;
        chk("flush_count", 64'(dut.r_count), 64'd0);
        chk("flush_cvalid", 64'(commit_valid_o), 64'd0);
        chk("flush_tid", 64'(issue_trans_id_o), 64'd0);
        chk("flush_ready", 64'(issue_ready_o), 64'd1);
        do_wb(0, 2'd1, 64'h77, 1'b0, 64'd0);
        chk("late_wb_occ", 64'(dut.r_occupied), 64'd0);
        chk("late_wb_cvalid", 64'(commit_valid_o), 64'd0);

        // Asynchronous reset between edges with live entries.
        do_issue(mk(5'd7, 1'b1, 1'b0, 64'd0));
        do_issue(mk(5'd8, 1'b1, 1'b0, 64'd0));
        rs1_i = 5'd7;
        #1;
        chk("pre_rst_hit", 64'(rs1_hit_o), 64'd1);
        chk("pre_rst_cvalid", 64'(commit_valid_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_ready", 64'(issue_ready_o), 64'd1);
        chk("arst_tid", 64'(issue_trans_id_o), 64'd0);
        chk("arst_cvalid", 64'(commit_valid_o), 64'd0);
        chk("arst_cinstr_nz", 64'(commit_instr_o != '0), 64'd0);
        chk("arst_rs1_hit", 64'(rs1_hit_o), 64'd0);
        chk("arst_rs1_valid", 64'(rs1_valid_o), 64'd0);
        chk("arst_rs1_data", rs1_o, 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
